// File: rtl/csa_accumulate_controller.sv
// Accumulates a stream of partial products through one carry-save stage, then
// resolves the redundant sum/carry pair lane-wise (8/16/32-bit lanes) into a plain result.
module csa_accumulate_controller #(
  parameter int ADDER_WIDTH = 32,
  parameter int COUNT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] op_count,
  input  logic [1:0]             precision,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [ADDER_WIDTH-1:0] op_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ADDER_WIDTH-1:0] res_data,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                 state;
  logic [ADDER_WIDTH-1:0] sum_q;
  logic [ADDER_WIDTH-1:0] carry_q;
  logic [COUNT_WIDTH-1:0] count;
  logic [1:0]             prec_q;

  logic [ADDER_WIDTH-1:0] kill;
  logic [ADDER_WIDTH-1:0] cs;
  logic [ADDER_WIDTH-1:0] csa_x;
  logic [ADDER_WIDTH-1:0] sum_next;
  logic [ADDER_WIDTH-1:0] carry_next;
  logic                   accept;

  // Lane-LSB positions: a carry shifted into these bits would cross a lane boundary.
  always_comb begin
    kill = '0;
    for (int i = 0; i < ADDER_WIDTH; i++) begin
      case (prec_q)
        2'b00:   kill[i] = ((i % 8) == 0);
        2'b01:   kill[i] = ((i % 16) == 0);
        default: kill[i] = ((i % 32) == 0);
      endcase
    end
  end

  assign accept = (state == ACCUM) && op_valid && op_ready;

  always_comb begin
    cs         = (carry_q << 1) & ~kill;
    csa_x      = (state == ACCUM) ? op_data : '0;
    sum_next   = sum_q ^ cs ^ csa_x;
    carry_next = (sum_q & cs) | (sum_q & csa_x) | (cs & csa_x);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sum_q     <= '0;
      carry_q   <= '0;
      count     <= '0;
      prec_q    <= '0;
      res_data  <= '0;
      op_ready  <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            count   <= op_count;
            prec_q  <= precision;
            sum_q   <= '0;
            carry_q <= '0;
            busy    <= 1'b1;
            if (op_count == '0) begin
              state     <= DONE;
              res_data  <= '0;
              res_valid <= 1'b1;
            end else begin
              state    <= ACCUM;
              op_ready <= 1'b1;
            end
          end
        end

        ACCUM: begin
          if (accept) begin
            sum_q   <= sum_next;
            carry_q <= carry_next;
            count   <= count - COUNT_WIDTH'(1);
            if (count == COUNT_WIDTH'(1)) begin
              state    <= RESOLVE;
              op_ready <= 1'b0;
            end
          end
        end

        RESOLVE: begin
          // With X=0 the pending carries ripple one position per cycle until none remain.
          if (cs == '0) begin
            res_data  <= sum_q;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            sum_q   <= sum_next;
            carry_q <= carry_next;
          end
        end

        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          op_ready  <= 1'b0;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulate_controller.sv
// Self-checking bench: directed vectors plus random jobs against a lane-wise arithmetic model.
module tb_csa_accumulate_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  op_count;
  logic [1:0]  precision;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_data;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] ops[$];
  logic [31:0] result;

  csa_accumulate_controller #(.ADDER_WIDTH(32), .COUNT_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op_count(op_count), .precision(precision),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Each lane is summed independently with ordinary integers and truncated.
  function automatic logic [31:0] model(input logic [1:0] prec);
    int lw;
    longint unsigned mask, s;
    logic [31:0] r;
    lw   = (prec == 2'b00) ? 8 : (prec == 2'b01) ? 16 : 32;
    mask = (64'd1 << lw) - 1;
    r    = '0;
    for (int l = 0; l < 32 / lw; l++) begin
      s = 0;
      foreach (ops[k]) s += (longint'(ops[k]) >> (l * lw)) & mask;
      r |= 32'((s & mask) << (l * lw));
    end
    return r;
  endfunction

  task automatic do_job(input logic [1:0] prec, input int hold, input bit gaps,
                        input string tag, output logic [31:0] res);
    int  idx, cyc, wcyc;
    bit  acc;
    logic [31:0] expv, held;
    expv      = model(prec);
    start     = 1'b1;
    op_count  = 5'(ops.size());
    precision = prec;
    step();
    start     = 1'b0;
    op_count  = 5'($urandom);
    precision = 2'($urandom);
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    idx = 0;
    cyc = 0;
    while (idx < ops.size() && cyc < 400) begin
      op_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      op_data  = op_valid ? ops[idx] : $urandom;
      start    = gaps ? 1'($urandom) : 1'b0;
      acc      = op_valid && op_ready;
      step();
      if (acc) idx++;
      cyc++;
      if (gaps) check({tag, "_busy_accum"}, 32'(busy), 32'd1);
    end
    op_valid = 1'b0;
    start    = 1'b0;
    check({tag, "_accepted"}, 32'(idx), 32'(ops.size()));
    wcyc = 0;
    while (!res_valid && wcyc < 60) begin
      if (op_ready) check({tag, "_op_ready_after_last"}, 32'(op_ready), 32'd0);
      step();
      wcyc++;
    end
    if (ops.size() == 0) begin
      check({tag, "_n0_latency_ok"}, 32'(wcyc <= 1), 32'd1);
      check({tag, "_n0_op_ready"}, 32'(op_ready), 32'd0);
    end
    check({tag, "_res_valid"}, 32'(res_valid), 32'd1);
    check({tag, "_res_data"}, res_data, expv);
    held = res_data;
    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      start = 1'($urandom);
      step();
      check({tag, "_hold_data"}, res_data, held);
      check({tag, "_hold_busy"}, 32'(busy), 32'd1);
      check({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
    end
    res_ready = 1'b1;
    start     = 1'b1;
    step();
    res_ready = 1'b0;
    start     = 1'b0;
    check({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    step();
    check({tag, "_no_restart"}, 32'(busy), 32'd0);
    res = held;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_count = '0; precision = '0;
    op_valid = 1'b0; op_data = '0; res_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset_op_ready", 32'(op_ready), 32'd0);
    check("reset_res_valid", 32'(res_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_res_data", res_data, 32'd0);

    ops = '{32'h00000001, 32'h000000FF, 32'hFFFFFF00};
    do_job(2'b10, 0, 1'b0, "p10_n3", result);
    check("p10_n3_const", result, 32'h00000000);

    ops = '{32'h01FF80FF, 32'h01018001};
    do_job(2'b00, 1, 1'b0, "p00_bytes", result);
    check("p00_bytes_const", result, 32'h02000000);

    ops = '{32'hFFFF0001, 32'h0001FFFF};
    do_job(2'b01, 0, 1'b0, "p01_half", result);
    check("p01_half_const", result, 32'h00000000);
    do_job(2'b10, 0, 1'b0, "p10_half", result);
    check("p10_half_const", result, 32'h00010000);
    do_job(2'b11, 0, 1'b0, "p11_half", result);
    check("p11_half_const", result, 32'h00010000);

    ops = {};
    do_job(2'b01, 2, 1'b0, "n0", result);
    check("n0_const", result, 32'h00000000);

    ops = '{32'h10, 32'h10, 32'h10, 32'h10};
    do_job(2'b10, 5, 1'b1, "bp", result);
    check("bp_const", result, 32'h00000040);

    // Abort a job halfway through with reset.
    start = 1'b1; op_count = 5'd4; precision = 2'b10;
    step();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      op_valid = 1'b1; op_data = 32'h12345678;
      step();
    end
    op_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_op_ready", 32'(op_ready), 32'd0);
    check("rst_mid_res_valid", 32'(res_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_res_data", res_data, 32'd0);
    ops = '{32'd7, 32'd9};
    do_job(2'b10, 0, 1'b0, "after_rst", result);
    check("after_rst_const", result, 32'h00000010);

    for (int j = 0; j < 25; j++) begin
      int n;
      n = (j % 8 == 7) ? 0 : $urandom_range(1, 31);
      ops = {};
      for (int k = 0; k < n; k++) ops.push_back($urandom);
      do_job(2'($urandom), $urandom_range(0, 3), 1'($urandom), "rand", result);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
